// File: rtl/vga_timing_gen.sv
// Raster timing generator: sync, display-enable, pixel coordinates and line/frame strobes.
// Define VGA_TIMING_FRAME_CNT_EN to build the 8-bit frame counter; otherwise frame_cnt is 0.
module vga_timing_gen #(
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    output logic       vga_h_sync,
    output logic       vga_v_sync,
    output logic       in_display,
    output logic [9:0] cnt_x,
    output logic [9:0] cnt_y,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_W = 11'(H_VIS);
    localparam logic [10:0] V_VIS_W = 11'(V_VIS);
    localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_VIS + V_FP + V_SYNC);
    localparam logic        HS_ACT  = 1'(H_SYNC_POL);
    localparam logic        VS_ACT  = 1'(V_SYNC_POL);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_cfg_err
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must each be <= 1024");
        end
    endgenerate

    logic [9:0] x_q, x_d, y_q, y_d;
    logic       hs_q, vs_q, disp_q, ls_q, fs_q;
    logic       hs_d, vs_d, disp_d, ls_d, fs_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clk_en) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        // Outputs are decoded from the next position so they line up with cnt_x/cnt_y.
        disp_d = ({1'b0, x_d} < H_VIS_W) && ({1'b0, y_d} < V_VIS_W);
        hs_d   = (({1'b0, x_d} >= HS_BEG) && ({1'b0, x_d} < HS_END)) ? HS_ACT : ~HS_ACT;
        vs_d   = (({1'b0, y_d} >= VS_BEG) && ({1'b0, y_d} < VS_END)) ? VS_ACT : ~VS_ACT;
        ls_d   = (x_d == '0);
        fs_d   = (x_d == '0) && (y_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q    <= H_LAST;
            y_q    <= V_LAST;
            disp_q <= 1'b0;
            hs_q   <= ~HS_ACT;
            vs_q   <= ~VS_ACT;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else if (clk_en) begin
            x_q    <= x_d;
            y_q    <= y_d;
            disp_q <= disp_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] fc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fc_q <= '0;
        end else if (clk_en && fs_d) begin
            fc_q <= fc_q + 8'd1;
        end
    end

    assign frame_cnt = fc_q;
`else
    assign frame_cnt = '0;
`endif

    assign cnt_x       = x_q;
    assign cnt_y       = y_q;
    assign in_display  = disp_q;
    assign vga_h_sync  = hs_q;
    assign vga_v_sync  = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line-level timing, plus a tiny raster
// instance (16x12, active-high h_sync) for frame-level timing and the frame counter.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_a = 1'b0;
    logic en_s = 1'b0;

    logic       a_hs, a_vs, a_disp, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic [7:0] a_fc;
    logic       s_hs, s_vs, s_disp, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic [7:0] s_fc;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut (
        .clk(clk), .rst_n(rst_n), .clk_en(en_a),
        .vga_h_sync(a_hs), .vga_v_sync(a_vs), .in_display(a_disp),
        .cnt_x(a_x), .cnt_y(a_y), .line_start(a_ls), .frame_start(a_fs),
        .frame_cnt(a_fc)
    );

    vga_timing_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .H_SYNC_POL(1), .V_SYNC_POL(0)
    ) u_sml (
        .clk(clk), .rst_n(rst_n), .clk_en(en_s),
        .vga_h_sync(s_hs), .vga_v_sync(s_vs), .in_display(s_disp),
        .cnt_x(s_x), .cnt_y(s_y), .line_start(s_ls), .frame_start(s_fs),
        .frame_cnt(s_fc)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One pixel on the default instance, then `gap` idle clocks; ends #1 after an edge.
    task automatic pix_a(input int gap);
        en_a = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
    endtask

    function automatic logic [7:0] exp_fc(input int frames);
`ifdef VGA_TIMING_FRAME_CNT_EN
        return 8'(frames);
`else
        return 8'd0;
`endif
    endfunction

    initial begin
        int ind, hsl, first, last, posmis;
        int mx, my, mism, fsn, since, ivl_bad, vs_cnt, ds_cnt, hs_cnt;

        // Reset held with enables high.
        en_a = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_x", 32'(a_x), 799);
        chk("rst_y", 32'(a_y), 524);
        chk("rst_disp", 32'(a_disp), 0);
        chk("rst_hs", 32'(a_hs), 1);
        chk("rst_vs", 32'(a_vs), 1);
        chk("rst_ls", 32'(a_ls), 0);
        chk("rst_fs", 32'(a_fs), 0);
        chk("rst_fc", 32'(a_fc), 0);
        chk("rst_s_x", 32'(s_x), 15);
        chk("rst_s_y", 32'(s_y), 11);
        chk("rst_s_hs", 32'(s_hs), 0);

        rst_n = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b0;
        chk("first_x", 32'(a_x), 0);
        chk("first_y", 32'(a_y), 0);
        chk("first_fs", 32'(a_fs), 1);
        chk("first_ls", 32'(a_ls), 1);
        chk("first_disp", 32'(a_disp), 1);

        // One full line, one pixel every 4th clock.
        ind = 0; hsl = 0; first = -1; last = -1; posmis = 0;
        for (int p = 0; p < 800; p++) begin
            if (p > 0) pix_a(3);
            if (int'(a_x) != p || a_y != 10'd0) posmis++;
            if (a_disp) ind++;
            if (!a_hs) begin
                if (first < 0) first = int'(a_x);
                last = int'(a_x);
                hsl++;
            end
        end
        chk("line_pos", 32'(posmis), 0);
        chk("line_disp_cnt", 32'(ind), 640);
        chk("line_hs_cnt", 32'(hsl), 96);
        chk("line_hs_first", 32'(first), 656);
        chk("line_hs_last", 32'(last), 751);
        pix_a(3);
        chk("wrap_x", 32'(a_x), 0);
        chk("wrap_y", 32'(a_y), 1);
        chk("wrap_ls", 32'(a_ls), 1);
        chk("wrap_fs", 32'(a_fs), 0);

        // Stall just before the h_sync window.
        repeat (655) pix_a(0);
        chk("pre_stall_x", 32'(a_x), 655);
        chk("pre_stall_hs", 32'(a_hs), 1);
        repeat (37) @(posedge clk);
        #1;
        chk("stall_x", 32'(a_x), 655);
        chk("stall_y", 32'(a_y), 1);
        chk("stall_hs", 32'(a_hs), 1);
        chk("stall_disp", 32'(a_disp), 0);
        pix_a(0);
        chk("post_stall_x", 32'(a_x), 656);
        chk("post_stall_hs", 32'(a_hs), 0);

        // Mid-frame reset with clk_en low.
        repeat (444) pix_a(0);
        chk("mid_x", 32'(a_x), 300);
        chk("mid_y", 32'(a_y), 2);
        chk("mid_disp", 32'(a_disp), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mrst_x", 32'(a_x), 799);
        chk("mrst_y", 32'(a_y), 524);
        chk("mrst_hs", 32'(a_hs), 1);
        chk("mrst_vs", 32'(a_vs), 1);
        chk("mrst_disp", 32'(a_disp), 0);
        chk("mrst_fs", 32'(a_fs), 0);
        pix_a(0);
        chk("rec_x", 32'(a_x), 0);
        chk("rec_y", 32'(a_y), 0);
        chk("rec_fs", 32'(a_fs), 1);
        chk("rec_ls", 32'(a_ls), 1);
        chk("rec_fc", 32'(a_fc), 32'(exp_fc(1)));

        // Small raster: 257 frames of 192 pixels against a reference model.
        mx = 15; my = 11; mism = 0; fsn = 0; since = 0; ivl_bad = 0;
        vs_cnt = 0; ds_cnt = 0; hs_cnt = 0;
        en_s = 1'b1;
        for (int i = 0; i < 257 * 192; i++) begin
            @(posedge clk); #1;
            if (mx == 15) begin
                mx = 0;
                my = (my == 11) ? 0 : my + 1;
            end else begin
                mx++;
            end
            since++;
            if (mx == 0 && my == 0) begin
                if (fsn > 0 && since != 192) ivl_bad++;
                fsn++;
                since = 0;
                if (fsn == 1 || fsn == 255 || fsn == 256 || fsn == 257)
                    chk($sformatf("fc_frame%0d", fsn), 32'(s_fc), 32'(exp_fc(fsn)));
            end
            if (int'(s_x) != mx || int'(s_y) != my) mism++;
            if (s_disp !== ((mx < 8) && (my < 6))) mism++;
            if (s_hs !== ((mx >= 10) && (mx <= 12))) mism++;
            if (s_vs !== !((my >= 8) && (my <= 9))) mism++;
            if (s_ls !== (mx == 0)) mism++;
            if (s_fs !== (mx == 0 && my == 0)) mism++;
            if (fsn == 1) begin
                if (!s_vs) vs_cnt++;
                if (s_disp) ds_cnt++;
                if (s_hs) hs_cnt++;
            end
        end
        en_s = 1'b0;
        chk("sml_model", 32'(mism), 0);
        chk("sml_frames", 32'(fsn), 257);
        chk("sml_interval", 32'(ivl_bad), 0);
        chk("sml_vs_cnt", 32'(vs_cnt), 32);
        chk("sml_disp_cnt", 32'(ds_cnt), 48);
        chk("sml_hs_cnt", 32'(hs_cnt), 36);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
